// File: rtl/contador_prog_sel.sv
// Debounced up/down select counter for the DPWM frequency mux.
// Optional auto-repeat on long holds: define CONTADOR_PROG_AUTOREPEAT_EN.
module contador_prog_sel #(
  parameter int WIDTH           = 3,
  parameter int MIN_VAL         = 0,
  parameter int MAX_VAL         = 7,
  parameter int RESET_VAL       = 0,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WRAP            = 1,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             boton_aumento,
  input  logic             boton_disminuye,
  input  logic             enable,
  output logic [WIDTH-1:0] numero_frec,
  output logic             cambio,
  output logic             en_max,
  output logic             en_min
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MIN_V    = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_V  = WIDTH'(RESET_VAL);

  generate
    if (MIN_VAL >= MAX_VAL || MAX_VAL > (2**WIDTH) - 1)
      $error("contador_prog_sel: need MIN_VAL < MAX_VAL <= 2^WIDTH-1");
    if (RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL)
      $error("contador_prog_sel: RESET_VAL outside MIN_VAL..MAX_VAL");
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
      $error("contador_prog_sel: cycle-count parameters must be >= 1");
  endgenerate

  // Bit 0 is the increment button, bit 1 the decrement button.
  logic [1:0] raw;
  logic [1:0] press;
  assign raw = {boton_disminuye, boton_aumento};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic             s1;
      logic             s2;
      logic             stable;
      logic             stable_q;
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          s1       <= 1'b0;
          s2       <= 1'b0;
          stable   <= 1'b0;
          stable_q <= 1'b0;
          cnt      <= '0;
        end else begin
          s1       <= raw[gi];
          s2       <= s1;
          stable_q <= stable;
          if (s2 == stable) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            stable <= s2;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

`ifdef CONTADOR_PROG_AUTOREPEAT_EN
      localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

      // hold_cnt equals the number of cycles stable has been high; after the
      // first repeat it restarts and counts towards REPEAT_PERIOD instead.
      logic [HOLD_W-1:0] hold_cnt;
      logic              rep_phase;
      logic              rep;

      assign rep = stable && (rep_phase ? (hold_cnt == HOLD_W'(REPEAT_PERIOD))
                                        : (hold_cnt == HOLD_W'(REPEAT_DELAY)));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          hold_cnt  <= '0;
          rep_phase <= 1'b0;
        end else if (!stable) begin
          hold_cnt  <= '0;
          rep_phase <= 1'b0;
        end else if (rep) begin
          hold_cnt  <= HOLD_W'(1);
          rep_phase <= 1'b1;
        end else begin
          hold_cnt  <= hold_cnt + 1'b1;
        end
      end

      assign press[gi] = (stable & ~stable_q) | rep;
`else
      assign press[gi] = stable & ~stable_q;
`endif
    end
  endgenerate

  logic [WIDTH-1:0] next_val;

  always_comb begin
    next_val = numero_frec;
    if (enable && press[0] && !press[1]) begin
      if (numero_frec >= MAX_V) next_val = (WRAP != 0) ? MIN_V : MAX_V;
      else                      next_val = numero_frec + 1'b1;
    end else if (enable && press[1] && !press[0]) begin
      if (numero_frec <= MIN_V) next_val = (WRAP != 0) ? MAX_V : MIN_V;
      else                      next_val = numero_frec - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      numero_frec <= RESET_V;
      cambio      <= 1'b0;
    end else begin
      numero_frec <= next_val;
      cambio      <= (next_val != numero_frec);
    end
  end

  assign en_max = (numero_frec == MAX_V);
  assign en_min = (numero_frec == MIN_V);

endmodule

// File: tb/tb_contador_prog_sel.sv
// Scoreboard bench for contador_prog_sel: one wrapping and one saturating instance share stimulus.
`timescale 1ns/1ps
module tb_contador_prog_sel;

  logic       clk = 1'b0;
  logic       reset;
  logic       up;
  logic       dn;
  logic       enable;
  logic [2:0] nf_w, nf_s;
  logic       cb_w, cb_s, mx_w, mx_s, mn_w, mn_s;

  always #5 clk = ~clk;

  contador_prog_sel #(.WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .boton_aumento(up), .boton_disminuye(dn), .enable(enable),
    .numero_frec(nf_w), .cambio(cb_w), .en_max(mx_w), .en_min(mn_w)
  );

  contador_prog_sel #(.WRAP(0)) dut_s (
    .clk(clk), .reset(reset), .boton_aumento(up), .boton_disminuye(dn), .enable(enable),
    .numero_frec(nf_s), .cambio(cb_s), .en_max(mx_s), .en_min(mn_s)
  );

`ifdef CONTADOR_PROG_AUTOREPEAT_EN
  localparam int HOLD_CHECK = 3;
`else
  localparam int HOLD_CHECK = 30;
`endif

  typedef struct { logic [2:0] w; logic [2:0] s; } exp_t;
  exp_t sb[$];

  int         vectors = 0;
  int         errors  = 0;
  logic [2:0] mw, ms;
  bit         early_bad;

  function automatic logic [2:0] step_model(input logic [2:0] v, input logic u, input logic d,
                                            input logic en, input bit wrap);
    if (!en || u == d) return v;
    if (u) return (v == 3'd7) ? (wrap ? 3'd0 : 3'd7) : v + 3'd1;
    return (v == 3'd0) ? (wrap ? 3'd7 : 3'd0) : v - 3'd1;
  endfunction

  // Drive a button pattern, queue the expected result, and stop right after the update edge.
  task automatic apply(input logic u, input logic d);
    exp_t e;
    e.w = step_model(mw, u, d, enable, 1'b1);
    e.s = step_model(ms, u, d, enable, 1'b0);
    sb.push_back(e);
    up = u;
    dn = d;
    early_bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (nf_w !== mw || nf_s !== ms || cb_w !== 1'b0 || cb_s !== 1'b0) early_bad = 1'b1;
    end
    @(negedge clk);
  endtask

  // Wait n cycles, flagging any cambio pulse or value drift from the model.
  task automatic settle(input int n, output bit bad);
    bad = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (nf_w !== mw || nf_s !== ms || cb_w !== 1'b0 || cb_s !== 1'b0) bad = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; up = 1'b0; dn = 1'b0; enable = 1'b1;
    mw = 3'd0; ms = 3'd0;
    repeat (3) @(negedge clk);
    vectors++; if (nf_w !== 3'd0) begin errors++; $display("FAIL reset_val: got %0d want 0", nf_w); end
    vectors++; if (cb_w !== 1'b0) begin errors++; $display("FAIL reset_cambio: got %b want 0", cb_w); end
    vectors++; if (mn_w !== 1'b1 || mx_w !== 1'b0) begin errors++; $display("FAIL reset_flags: min=%b max=%b want 1/0", mn_w, mx_w); end
    vectors++; if (nf_s !== 3'd0) begin errors++; $display("FAIL reset_val_sat: got %0d want 0", nf_s); end
    reset = 1'b1;
    @(negedge clk);
    $display("reset: numero_frec=%0d en_min=%b", nf_w, mn_w);
  endtask

  task automatic test_clean_press;
    exp_t e;
    bit   bad;
    apply(1'b1, 1'b0);
    e = sb.pop_front();
    vectors++; if (early_bad) begin errors++; $display("FAIL press_latency: early change/cambio before edge k+6"); end
    vectors++; if (nf_w !== e.w) begin errors++; $display("FAIL press_val: got %0d want %0d", nf_w, e.w); end
    vectors++; if (cb_w !== 1'b1) begin errors++; $display("FAIL press_cambio: got %b want 1", cb_w); end
    mw = e.w; ms = e.s;
    settle(HOLD_CHECK, bad);
    vectors++; if (bad) begin errors++; $display("FAIL press_hold: extra step or cambio while held"); end
    up = 1'b0;
    settle(8, bad);
    vectors++; if (bad) begin errors++; $display("FAIL press_release: release produced a step"); end
    $display("clean press: numero_frec=%0d", nf_w);
  endtask

  task automatic test_bounce;
    bit bad;
    for (int len = 1; len <= 3; len++) begin
      bad = 1'b0;
      for (int rep = 0; rep < 3; rep++) begin
        up = 1'b1;
        repeat (len) begin
          @(negedge clk);
          if (nf_w !== mw || cb_w !== 1'b0) bad = 1'b1;
        end
        up = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (nf_w !== mw || cb_w !== 1'b0) bad = 1'b1;
        end
      end
      vectors++; if (bad) begin errors++; $display("FAIL bounce_len%0d: got %0d want %0d", len, nf_w, mw); end
      $display("bounce %0d-cycle pulses: numero_frec=%0d", len, nf_w);
    end
    settle(8, bad);
    vectors++; if (bad) begin errors++; $display("FAIL bounce_tail: late step after glitches"); end
  endtask

  task automatic test_wrap_saturate;
    logic seq_up [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    exp_t e;
    bit   bad;
    for (int i = 0; i < 10; i++) begin
      apply(seq_up[i], ~seq_up[i]);
      e = sb.pop_front();
      vectors++; if (early_bad) begin errors++; $display("FAIL wrap%0d_latency: early change", i); end
      vectors++; if (nf_w !== e.w || cb_w !== (e.w != mw)) begin
        errors++; $display("FAIL wrap%0d_wrapinst: val=%0d cambio=%b want %0d/%b", i, nf_w, cb_w, e.w, e.w != mw);
      end
      vectors++; if (nf_s !== e.s || cb_s !== (e.s != ms)) begin
        errors++; $display("FAIL wrap%0d_satinst: val=%0d cambio=%b want %0d/%b", i, nf_s, cb_s, e.s, e.s != ms);
      end
      vectors++; if (mx_s !== (e.s == 3'd7) || mn_w !== (e.w == 3'd0)) begin
        errors++; $display("FAIL wrap%0d_flags: max_s=%b min_w=%b want %b/%b", i, mx_s, mn_w, e.s == 3'd7, e.w == 3'd0);
      end
      mw = e.w; ms = e.s;
      up = 1'b0; dn = 1'b0;
      settle(8, bad);
      vectors++; if (bad) begin errors++; $display("FAIL wrap%0d_release: spurious step", i); end
      $display("step %0d %s: wrap=%0d sat=%0d", i, seq_up[i] ? "up" : "dn", nf_w, nf_s);
    end
  endtask

  task automatic test_simultaneous_enable;
    exp_t e;
    bit   bad;
    apply(1'b1, 1'b1);
    e = sb.pop_front();
    vectors++; if (early_bad || nf_w !== e.w || cb_w !== 1'b0 || nf_s !== e.s) begin
      errors++; $display("FAIL both_pressed: got %0d cambio=%b want %0d cambio=0", nf_w, cb_w, e.w);
    end
    up = 1'b0; dn = 1'b0;
    settle(8, bad);
    vectors++; if (bad) begin errors++; $display("FAIL both_release: spurious step"); end
    $display("simultaneous: numero_frec=%0d", nf_w);

    enable = 1'b0;
    apply(1'b1, 1'b0);
    e = sb.pop_front();
    vectors++; if (early_bad || nf_w !== e.w || cb_w !== 1'b0) begin
      errors++; $display("FAIL enable_low: got %0d cambio=%b want %0d cambio=0", nf_w, cb_w, e.w);
    end
    enable = 1'b1;
    settle(3, bad);
    vectors++; if (bad) begin errors++; $display("FAIL enable_rise: queued press appeared (got %0d want %0d)", nf_w, mw); end
    up = 1'b0;
    settle(8, bad);
    vectors++; if (bad) begin errors++; $display("FAIL enable_release: spurious step"); end
    $display("enable low then high: numero_frec=%0d", nf_w);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit   bad;
    up = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++; if (nf_w !== 3'd0 || cb_w !== 1'b0 || mn_w !== 1'b1) begin
      errors++; $display("FAIL async_reset: val=%0d cambio=%b min=%b want 0/0/1", nf_w, cb_w, mn_w);
    end
    mw = 3'd0; ms = 3'd0;
    @(negedge clk);
    reset = 1'b1;
    apply(1'b1, 1'b0);
    e = sb.pop_front();
    vectors++; if (early_bad) begin errors++; $display("FAIL held_after_reset_latency: early change"); end
    vectors++; if (nf_w !== e.w || cb_w !== 1'b1) begin
      errors++; $display("FAIL held_after_reset: got %0d cambio=%b want %0d cambio=1", nf_w, cb_w, e.w);
    end
    mw = e.w; ms = e.s;
    up = 1'b0;
    settle(8, bad);
    vectors++; if (bad) begin errors++; $display("FAIL held_after_reset_release: spurious step"); end
    $display("reset mid-debounce then held: numero_frec=%0d", nf_w);
  endtask

`ifdef CONTADOR_PROG_AUTOREPEAT_EN
  task automatic test_autorepeat;
    exp_t e;
    int   pulses_w = 0;
    int   pulses_s = 0;
    int   want_w   = 0;
    int   want_s   = 0;
    e.w = mw; e.s = ms;
    for (int i = 0; i < 6; i++) begin
      if (step_model(e.w, 1'b1, 1'b0, 1'b1, 1'b1) != e.w) want_w++;
      if (step_model(e.s, 1'b1, 1'b0, 1'b1, 1'b0) != e.s) want_s++;
      e.w = step_model(e.w, 1'b1, 1'b0, 1'b1, 1'b1);
      e.s = step_model(e.s, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    sb.push_back(e);
    up = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (cb_w === 1'b1) pulses_w++;
      if (cb_s === 1'b1) pulses_s++;
    end
    up = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (cb_w === 1'b1) pulses_w++;
      if (cb_s === 1'b1) pulses_s++;
    end
    e = sb.pop_front();
    vectors++; if (nf_w !== e.w) begin errors++; $display("FAIL repeat_val: got %0d want %0d", nf_w, e.w); end
    vectors++; if (nf_s !== e.s) begin errors++; $display("FAIL repeat_val_sat: got %0d want %0d", nf_s, e.s); end
    vectors++; if (pulses_w != want_w) begin errors++; $display("FAIL repeat_pulses: got %0d want %0d", pulses_w, want_w); end
    vectors++; if (pulses_s != want_s) begin errors++; $display("FAIL repeat_pulses_sat: got %0d want %0d", pulses_s, want_s); end
    mw = e.w; ms = e.s;
    $display("autorepeat hold: numero_frec=%0d pulses=%0d", nf_w, pulses_w);
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap_saturate();
    test_simultaneous_enable();
    test_reset_mid();
`ifdef CONTADOR_PROG_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
